// File: rtl/register_pkg.sv
// Op codes shared by the register bank and its ALU.
package register_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_LOAD = 3'd0;
  localparam logic [OP_W-1:0] OP_INC  = 3'd1;
  localparam logic [OP_W-1:0] OP_DEC  = 3'd2;
  localparam logic [OP_W-1:0] OP_ASL  = 3'd3;
  localparam logic [OP_W-1:0] OP_LSR  = 3'd4;
  localparam logic [OP_W-1:0] OP_ROL  = 3'd5;
  localparam logic [OP_W-1:0] OP_ROR  = 3'd6;
  localparam logic [OP_W-1:0] OP_CLR  = 3'd7;
endpackage

// File: rtl/register_alu.sv
// Unary op unit: computes the new register value and carry for one write.
module register_alu
  import register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic             ci_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o
);

  // Result and carry selection; ops that leave carry alone pass c_i through.
  always_comb begin
    res_o = '0;
    c_o   = c_i;
    case (op_i)
      OP_LOAD: res_o = in_i;
      OP_INC:  res_o = r_i + WIDTH'(1);
      OP_DEC:  res_o = r_i - WIDTH'(1);
      OP_ASL:  begin res_o = {r_i[WIDTH-2:0], 1'b0}; c_o = r_i[WIDTH-1]; end
      OP_LSR:  begin res_o = {1'b0, r_i[WIDTH-1:1]}; c_o = r_i[0];       end
      OP_ROL:  begin res_o = {r_i[WIDTH-2:0], ci_i}; c_o = r_i[WIDTH-1]; end
      OP_ROR:  begin res_o = {ci_i, r_i[WIDTH-1:1]}; c_o = r_i[0];       end
      OP_CLR:  begin res_o = '0;                     c_o = 1'b0;         end
      default: begin res_o = '0;                     c_o = c_i;          end
    endcase
  end

endmodule

// File: rtl/register_bank.sv
// Bank of NREGS registers with one op-applying write port, two combinational
// read ports and registered Z/N/C flags reflecting the last accepted write.
module register_bank
  import register_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NREGS     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              ADDR_W    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [OP_W-1:0]   OP,
  input  logic [WIDTH-1:0]  IN,
  input  logic              CI,
  input  logic [ADDR_W-1:0] RADDR_A,
  input  logic [ADDR_W-1:0] RADDR_B,
  output logic [WIDTH-1:0]  OUT_A,
  output logic [WIDTH-1:0]  OUT_B,
  output logic              FLAG_Z,
  output logic              FLAG_N,
  output logic              FLAG_C
);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic                        z_q, n_q, c_q;
  logic                        z_d, n_d, c_d;
  logic                        wr_en;
  logic [WIDTH-1:0]            r_sel, alu_res;
  logic                        alu_c;

  // Out-of-range addresses (non power-of-two NREGS) are silently ignored.
  assign wr_en = CE && (int'(WADDR) < NREGS);

  // Operand fetch; zero when the write is not going to happen.
  always_comb begin
    r_sel = '0;
    if (wr_en) r_sel = regs_q[WADDR];
  end

  register_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i  (OP),
    .r_i   (r_sel),
    .in_i  (IN),
    .ci_i  (CI),
    .c_i   (c_q),
    .res_o (alu_res),
    .c_o   (alu_c)
  );

  // Next-state: only the addressed register and the flags move on a write.
  always_comb begin
    regs_d = regs_q;
    z_d    = z_q;
    n_d    = n_q;
    c_d    = c_q;
    if (wr_en) begin
      regs_d[WADDR] = alu_res;
      z_d           = (alu_res == '0);
      n_d           = alu_res[WIDTH-1];
      c_d           = alu_c;
    end
  end

  // State registers; async reset wins over any write on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs_q <= {NREGS{RESET_VAL}};
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
    end else begin
      regs_q <= regs_d;
      z_q    <= z_d;
      n_q    <= n_d;
      c_q    <= c_d;
    end
  end

  // Read ports: no write bypass, so a same-cycle read sees the old value.
  always_comb begin
    OUT_A = '0;
    OUT_B = '0;
    if (int'(RADDR_A) < NREGS) OUT_A = regs_q[RADDR_A];
    if (int'(RADDR_B) < NREGS) OUT_B = regs_q[RADDR_B];
  end

  assign FLAG_Z = z_q;
  assign FLAG_N = n_q;
  assign FLAG_C = c_q;

endmodule
